// File: rtl/cr_sa_dump_sched.sv
// Snapshot/clear scheduler and counter-bank dump streamer for the statistics aggregator.
// Optional build macro CR_SA_DUMP_SKIP_ZERO_EN suppresses zero-valued words except the last.
module cr_sa_dump_sched #(
    parameter int unsigned NUM_CTRS      = 64,
    parameter int unsigned CNT_W         = 50,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic [31:0]      cfg_interval,
    input  logic             cfg_clear_on_snap,
    input  logic             sw_snap_req,
    input  logic             sw_clear_req,
    output logic             sa_snap,
    output logic             sa_clear,
    output logic [5:0]       rd_idx,
    input  logic [CNT_W-1:0] rd_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [63:0]      dump_data,
    output logic             dump_last,
    output logic             busy,
    output logic [15:0]      overrun_cnt
);

    typedef enum logic [3:0] {
        StIdle, StSnap, StSclr, StClr, StSettle, StRead, StCap, StSend, StDone
    } state_e;

    localparam logic [5:0] LastIdx = 6'(NUM_CTRS - 1);
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_e          state_q;
    logic [31:0]     timer_q;
    logic            snap_lvl_q, clr_lvl_q;
    logic            snap_pend_q, clr_pend_q;
    logic [15:0]     ovr_q;
    logic [5:0]      idx_q;
    logic [SetW-1:0] settle_q;
    logic [7:0]      seq_q;
    logic            sa_snap_q, sa_clear_q;
    logic            dump_valid_q, dump_last_q;
    logic [63:0]     dump_data_q;

    logic        timer_run, timer_hit;
    logic        snap_edge, clr_edge, snap_req, snap_ovr;
    logic [49:0] value;
    logic [63:0] cap_word;

    always_comb begin
        timer_run = cfg_enable && (cfg_interval != 32'd0);
        // >= rather than == so a shrinking interval cannot strand the timer above the wrap point
        timer_hit = timer_run && (timer_q >= cfg_interval - 32'd1);
        snap_edge = sw_snap_req & ~snap_lvl_q;
        clr_edge  = sw_clear_req & ~clr_lvl_q;
        snap_req  = timer_hit | snap_edge;
        snap_ovr  = snap_req && (snap_pend_q || (state_q != StIdle));
        value     = 50'(rd_data);
        cap_word  = {idx_q, seq_q, value};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            snap_lvl_q   <= 1'b0;
            clr_lvl_q    <= 1'b0;
            snap_pend_q  <= 1'b0;
            clr_pend_q   <= 1'b0;
            ovr_q        <= '0;
            idx_q        <= '0;
            settle_q     <= '0;
            seq_q        <= '0;
            sa_snap_q    <= 1'b0;
            sa_clear_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            dump_data_q  <= '0;
        end else begin
            snap_lvl_q <= sw_snap_req;
            clr_lvl_q  <= sw_clear_req;

            if (!timer_run || timer_hit) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end

            if (snap_ovr && (ovr_q != 16'hFFFF)) begin
                ovr_q <= ovr_q + 16'd1;
            end

            if (snap_req) begin
                snap_pend_q <= 1'b1;
            end else if (state_q == StSnap) begin
                snap_pend_q <= 1'b0;
            end

            if (clr_edge) begin
                clr_pend_q <= 1'b1;
            end else if ((state_q == StSclr) || (state_q == StClr)) begin
                clr_pend_q <= 1'b0;
            end

            sa_snap_q  <= 1'b0;
            sa_clear_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (snap_pend_q) begin
                        state_q   <= StSnap;
                        sa_snap_q <= 1'b1;
                    end else if (clr_pend_q) begin
                        state_q    <= StClr;
                        sa_clear_q <= 1'b1;
                    end
                end
                StSnap: begin
                    if (cfg_clear_on_snap || clr_pend_q) begin
                        state_q    <= StSclr;
                        sa_clear_q <= 1'b1;
                    end else begin
                        state_q  <= StSettle;
                        settle_q <= '0;
                    end
                end
                StSclr: begin
                    state_q  <= StSettle;
                    settle_q <= '0;
                end
                StClr: begin
                    state_q <= StIdle;
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        idx_q   <= '0;
                        state_q <= StRead;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StRead: begin
                    state_q <= StCap;
                end
                StCap: begin
`ifdef CR_SA_DUMP_SKIP_ZERO_EN
                    if ((value == '0) && (idx_q != LastIdx)) begin
                        idx_q   <= idx_q + 6'd1;
                        state_q <= StRead;
                    end else begin
                        dump_data_q  <= cap_word;
                        dump_valid_q <= 1'b1;
                        dump_last_q  <= (idx_q == LastIdx);
                        state_q      <= StSend;
                    end
`else
                    dump_data_q  <= cap_word;
                    dump_valid_q <= 1'b1;
                    dump_last_q  <= (idx_q == LastIdx);
                    state_q      <= StSend;
`endif
                end
                StSend: begin
                    if (dump_ready) begin
                        dump_valid_q <= 1'b0;
                        dump_last_q  <= 1'b0;
                        if (dump_last_q) begin
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 6'd1;
                            state_q <= StRead;
                        end
                    end
                end
                StDone: begin
                    seq_q   <= seq_q + 8'd1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // rd_idx tracks idx directly; idx only moves on entry to READ, so it holds elsewhere
    assign rd_idx      = idx_q;
    assign sa_snap     = sa_snap_q;
    assign sa_clear    = sa_clear_q;
    assign dump_valid  = dump_valid_q;
    assign dump_last   = dump_last_q;
    assign dump_data   = dump_data_q;
    assign busy        = (state_q != StIdle);
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_cr_sa_dump_sched.sv
// Scoreboard bench for cr_sa_dump_sched: expected dump words are queued on each snapshot pulse
// from a per-counter value model and popped by a monitor on every handshake.
module tb_cr_sa_dump_sched;

    localparam int NUM = 64;
    localparam int CW  = 50;

    logic          clk = 1'b0;
    logic          rst, cfg_enable, cfg_clear_on_snap, sw_snap_req, sw_clear_req, dump_ready;
    logic [31:0]   cfg_interval;
    logic [CW-1:0] rd_data;
    logic          sa_snap, sa_clear, dump_valid, dump_last, busy;
    logic [5:0]    rd_idx;
    logic [63:0]   dump_data;
    logic [15:0]   overrun_cnt;

    always #5 clk = ~clk;

    cr_sa_dump_sched dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_enable        (cfg_enable),
        .cfg_interval      (cfg_interval),
        .cfg_clear_on_snap (cfg_clear_on_snap),
        .sw_snap_req       (sw_snap_req),
        .sw_clear_req      (sw_clear_req),
        .sa_snap           (sa_snap),
        .sa_clear          (sa_clear),
        .rd_idx            (rd_idx),
        .rd_data           (rd_data),
        .dump_valid        (dump_valid),
        .dump_ready        (dump_ready),
        .dump_data         (dump_data),
        .dump_last         (dump_last),
        .busy              (busy),
        .overrun_cnt       (overrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [49:0] v_mult = 50'd3;
    logic [49:0] v_base = 50'd0;
    bit          zmode  = 1'b0;

    logic [64:0] exp_q[$];
    logic [7:0]  model_seq = 8'd0;
    int          cyc = 0, n_snap = 0, n_clear = 0, n_words = 0;
    int          snap_cyc = 0, clear_cyc = 0;

    function automatic logic [49:0] ref_val(input int idx);
        if (zmode) return (idx == 4 || idx == 10) ? 50'(idx * 7 + 1) : 50'd0;
        return v_base + v_mult * 50'(idx);
    endfunction

    function automatic bit emitted(input int idx, input logic [49:0] v);
`ifdef CR_SA_DUMP_SKIP_ZERO_EN
        return (v != 50'd0) || (idx == NUM - 1);
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counter-bank snapshot mux: value for rd_idx is ready well before the CAP edge
    initial begin
        rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_data = ref_val(int'(rd_idx));
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            model_seq = 8'd0;
        end else begin
            if (sa_snap) begin
                n_snap++;
                snap_cyc = cyc;
                chk("snap_clear_exclusive", {63'd0, sa_clear}, 64'd0);
                for (int i = 0; i < NUM; i++) begin
                    if (emitted(i, ref_val(i)))
                        exp_q.push_back({(i == NUM - 1), 6'(i), model_seq, ref_val(i)});
                end
                model_seq = model_seq + 8'd1;
            end
            if (sa_clear) begin
                n_clear++;
                clear_cyc = cyc;
            end
            if (dump_valid) begin
                if (exp_q.size() == 0) begin
                    chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
                end else begin
                    chk("dump_data", dump_data, exp_q[0][63:0]);
                    chk("dump_last", {63'd0, dump_last}, {63'd0, exp_q[0][64]});
                    if (dump_ready) begin
                        void'(exp_q.pop_front());
                        n_words++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_snap();
        sw_snap_req = 1'b1;
        tick(2);
        sw_snap_req = 1'b0;
        tick(2);
    endtask

    task automatic pulse_clear();
        sw_clear_req = 1'b1;
        tick(2);
        sw_clear_req = 1'b0;
        tick(2);
    endtask

    task automatic wait_quiet(input string name, input bit rand_bp);
        int idle = 0;
        int n = 0;
        while (idle < 8 && n < 8000) begin
            if (rand_bp) dump_ready = ($urandom_range(0, 3) != 0);
            tick(1);
            n++;
            idle = busy ? 0 : idle + 1;
        end
        dump_ready = 1'b1;
        chk(name, 64'(idle >= 8), 64'd1);
    endtask

    task automatic wait_word(input int idx, input string name);
        int n = 0;
        while (!(dump_valid && dump_data[63:58] == 6'(idx)) && n < 3000) begin
            tick(1);
            n++;
        end
        chk(name, 64'(n < 3000), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_sa_snap"}, {63'd0, sa_snap}, 64'd0);
        chk({tag, "_sa_clear"}, {63'd0, sa_clear}, 64'd0);
        chk({tag, "_dump_valid"}, {63'd0, dump_valid}, 64'd0);
        chk({tag, "_dump_last"}, {63'd0, dump_last}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_overrun"}, {48'd0, overrun_cnt}, 64'd0);
        chk({tag, "_rd_idx"}, {58'd0, rd_idx}, 64'd0);
        chk({tag, "_dump_data"}, dump_data, 64'd0);
    endtask

    initial begin
        int n, s0, c0, w0;
        rst = 1'b1;
        cfg_enable = 1'b0;
        cfg_interval = 32'd0;
        cfg_clear_on_snap = 1'b0;
        sw_snap_req = 1'b0;
        sw_clear_req = 1'b0;
        dump_ready = 1'b1;
        tick(4);
        check_zero_outputs("reset");

        // Periodic timer with interval 100 produces the first snapshot
        cfg_interval = 32'd100;
        cfg_enable = 1'b1;
        rst = 1'b0;
        n = 0;
        while (!sa_snap && n < 300) begin
            tick(1);
            n++;
        end
        cfg_enable = 1'b0;
        chk("timer_snap_cycle", 64'(n >= 99 && n <= 101), 64'd1);
        chk("busy_in_dump", {63'd0, busy}, 64'd1);
        w0 = n_words;
        wait_quiet("dump1_quiet", 1'b0);
        chk("dump1_words", 64'(n_words - w0), 64'(NUM));
        chk("dump1_snaps", 64'(n_snap), 64'd1);
        chk("dump1_overrun", {48'd0, overrun_cnt}, 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);

        // Two software requests during a dump merge into one extra dump
        v_mult = {$urandom, $urandom} & 50'h3FFFF_FFFFFFFF;
        v_base = {$urandom, $urandom} & 50'h3FFFF_FFFFFFFF;
        s0 = n_snap;
        pulse_snap();
        wait_word(10, "ovr_reach_word10");
        pulse_snap();
        pulse_snap();
        wait_quiet("ovr_quiet", 1'b0);
        chk("ovr_snaps", 64'(n_snap - s0), 64'd2);
        chk("ovr_count", {48'd0, overrun_cnt}, 64'd2);
        chk("ovr_queue_empty", 64'(exp_q.size()), 64'd0);

        // Clear-on-snap: clear lands exactly one cycle after the snap
        cfg_clear_on_snap = 1'b1;
        s0 = n_snap;
        c0 = n_clear;
        pulse_snap();
        wait_quiet("cos_quiet", 1'b0);
        cfg_clear_on_snap = 1'b0;
        chk("cos_clear_follows", 64'(clear_cyc - snap_cyc), 64'd1);
        chk("cos_clears", 64'(n_clear - c0), 64'd1);
        chk("cos_snaps", 64'(n_snap - s0), 64'd1);

        // Standalone clear: pulse only, no dump
        s0 = n_snap;
        c0 = n_clear;
        w0 = n_words;
        pulse_clear();
        wait_quiet("clr_quiet", 1'b0);
        chk("clr_clears", 64'(n_clear - c0), 64'd1);
        chk("clr_snaps", 64'(n_snap - s0), 64'd0);
        chk("clr_words", 64'(n_words - w0), 64'd0);

        // Clear during a dump is deferred until after the dump
        s0 = n_snap;
        c0 = n_clear;
        pulse_snap();
        wait_word(3, "dclr_reach_word3");
        pulse_clear();
        wait_quiet("dclr_quiet", 1'b0);
        chk("dclr_clears", 64'(n_clear - c0), 64'd1);
        chk("dclr_after_dump", 64'(clear_cyc > snap_cyc + 150), 64'd1);

        // Backpressure: ten stall cycles on word 5
        pulse_snap();
        wait_word(5, "stall_reach_word5");
        dump_ready = 1'b0;
        tick(10);
        chk("stall_held_valid", {63'd0, dump_valid}, 64'd1);
        chk("stall_held_idx", {58'd0, dump_data[63:58]}, 64'd5);
        dump_ready = 1'b1;
        wait_quiet("stall_quiet", 1'b0);
        chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        // Randomized values, clear-on-snap and backpressure
        for (int r = 0; r < 3; r++) begin
            v_mult = {$urandom, $urandom} & 50'h3FFFF_FFFFFFFF;
            v_base = {$urandom, $urandom} & 50'h3FFFF_FFFFFFFF;
            cfg_clear_on_snap = $urandom_range(0, 1);
            pulse_snap();
            wait_quiet("rand_quiet", 1'b1);
            chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        end
        cfg_clear_on_snap = 1'b0;

        // Reset mid-dump, then a fresh dump restarts at idx 0, seq 0
        v_mult = 50'd3;
        v_base = 50'd0;
        pulse_snap();
        wait_word(30, "rst_reach_word30");
        rst = 1'b1;
        tick(1);
        check_zero_outputs("midrst");
        tick(1);
        rst = 1'b0;
        tick(2);
        pulse_snap();
        wait_word(0, "rst_fresh_word0");
        chk("rst_fresh_seq", {56'd0, dump_data[57:50]}, 64'd0);
        wait_quiet("rst_fresh_quiet", 1'b0);
        chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef CR_SA_DUMP_SKIP_ZERO_EN
        zmode = 1'b1;
        w0 = n_words;
        pulse_snap();
        wait_quiet("skip_quiet", 1'b0);
        chk("skip_words", 64'(n_words - w0), 64'd3);
        chk("skip_queue_empty", 64'(exp_q.size()), 64'd0);
        zmode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
